// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared defaults and FSM encoding for the register-file writer
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;

  // A one-entry file still needs a one-bit index.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/reg_wr_decoder.sv
// ============================================================================
// reg_wr_decoder : index + enable to one-hot register write strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_wr_decoder
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = addr_w(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DEPTH-1:0]  sel_o
);

  // Indices at or beyond DEPTH match no bit, so such writes land nowhere.
  for (genvar i = 0; i < DEPTH; i++) begin : g_sel
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign sel_o[i] = 1'b0;
    end else begin : g_dec
      assign sel_o[i] = en_i && (addr_i == ADDR_W'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_bank.sv
// ============================================================================
// reg_write_bank : 32x32 register storage with write commit and bulk clear
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_write_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = addr_w(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  output logic                   wr_ack,
  output logic [ADDR_W-1:0]      wr_ack_addr,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic [DEPTH*WIDTH-1:0] regs_flat
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_ack_q;
  logic [ADDR_W-1:0] wr_ack_addr_q;
  logic              clr_done_q;
  logic [WIDTH-1:0]  regs_q [DEPTH];

  logic              idle_w, clear_w, accept_w, last_w;
  logic              sel_en_w;
  logic [ADDR_W-1:0] sel_addr_w;
  logic [WIDTH-1:0]  commit_data_w;
  logic [DEPTH-1:0]  sel_w;

  assign idle_w   = (state_q == ST_IDLE);
  assign clear_w  = (state_q == ST_CLEAR);
  assign accept_w = wr_en && idle_w;
  assign last_w   = clear_w && (cnt_q == ADDR_W'(DEPTH - 1));

  // One decoder serves both writers: the clear counter owns it while clearing.
  assign sel_en_w      = clear_w || accept_w;
  assign sel_addr_w    = clear_w ? cnt_q : wr_addr;
  assign commit_data_w = clear_w ? '0 : wr_data;

  reg_wr_decoder #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_dec (
    .en_i   (sel_en_w),
    .addr_i (sel_addr_w),
    .sel_o  (sel_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (last_w) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wr_ack_q      <= 1'b0;
      wr_ack_addr_q <= '0;
      clr_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_ack_q      <= accept_w;
      wr_ack_addr_q <= accept_w ? wr_addr : wr_ack_addr_q;
      clr_done_q    <= last_w;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (sel_w[i]) begin
        regs_q[i] <= commit_data_w;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
  end

  assign wr_ready    = idle_w;
  assign clr_busy    = clear_w;
  assign wr_ack      = wr_ack_q;
  assign wr_ack_addr = wr_ack_addr_q;
  assign clr_done    = clr_done_q;

endmodule

`default_nettype wire

// File: doc/reg_write_bank.md
Name: reg_write_bank

Overview:
- Write side of the register file: 32 x 32-bit storage, write-address decode and commit, plus a sequenced bulk-clear engine.
- Exposes all registers as one flat bus that feeds the 32:1 read-select muxes.
- Sits between the write-back stage and the read muxes. It is the writer end of the register-file interface.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers.
- ADDR_W, $clog2(DEPTH), width of the write and clear address.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  destination register index.
- wr_data  input  WIDTH  write data.
- wr_ready  output  1  a write is accepted this cycle when wr_en and wr_ready are both high.
- wr_ack  output  1  one-cycle pulse the cycle after a write is accepted.
- wr_ack_addr  output  ADDR_W  index of the acknowledged write; valid while wr_ack is high.
- clr_req  input  1  request to zero all registers sequentially.
- clr_busy  output  1  clear sequence in progress.
- clr_done  output  1  one-cycle pulse when the clear completes.
- regs_flat  output  DEPTH*WIDTH  register contents; register i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (clk edge with rst=1):
  - All registers 0; state IDLE; clear counter 0.
  - wr_ack=0, wr_ack_addr=0, clr_done=0, clr_busy=0, wr_ready=1.
  - Reset overrides every other input, including mid-clear. A write presented in the reset cycle is lost.
- FSM states: IDLE and CLEAR.
  - wr_ready = (state==IDLE), decoded from the state register. clr_busy = (state==CLEAR).
- Write path in IDLE:
  - When wr_en=1, reg[wr_addr] <= wr_data on that edge.
  - Latency 1: the new value is visible on regs_flat the following cycle.
  - wr_ack=1 and wr_ack_addr=wr_addr in the next cycle, for one cycle only.
  - Back-to-back writes are allowed every cycle. A later write to the same index wins.
- Register 0 with ZERO_REG=1: the write is accepted and acknowledged, but storage stays 0.
- Out-of-range index (wr_addr >= DEPTH): the write is accepted and acknowledged; no register changes.
- Writes during CLEAR: wr_ready=0, so wr_en is ignored and no wr_ack is produced. The writer must hold the request.
- Clear sequence:
  - clr_req=1 in IDLE moves the FSM to CLEAR on that edge; the counter starts at 0.
  - Each CLEAR cycle zeroes reg[counter] and increments the counter.
  - After the cycle that clears index DEPTH-1, the FSM returns to IDLE. The counter resets to 0.
  - clr_done=1 for exactly the first IDLE cycle after CLEAR.
  - Total: DEPTH cycles with clr_busy=1, then clr_done.
  - clr_req while in CLEAR is ignored; it neither restarts nor extends the sequence.
  - clr_req held high continuously starts a new clear in the clr_done cycle.
- wr_en and clr_req together in IDLE: the write commits and is acknowledged; CLEAR begins the next cycle. The written register is therefore zeroed by the end of the clear.
- regs_flat is driven directly from storage with no output logic.

Decomposition:
- Shared package (regfile_pkg): WIDTH/DEPTH defaults, the ADDR_W derivation, and the state encoding constants ST_IDLE/ST_CLEAR.
- One sub-module is natural: reg_wr_decoder, combinational, mapping addr+en to a DEPTH-bit one-hot enable with zero-register masking.
  - It is used for both the write index and the clear counter, selected by state.
- Storage and the FSM live in the top level.

Test Plan:
1. Reset write: assert rst while driving wr_en=1, wr_addr=5 -> after release all regs_flat=0, wr_ready=1, clr_busy=0, no wr_ack.
2. Basic write: wr_en=1, wr_addr=7, wr_data=0xDEADBEEF for one cycle -> next cycle reg7=0xDEADBEEF and wr_ack=1 with wr_ack_addr=7; all other regs unchanged; wr_ack low the cycle after.
3. Zero register and same-index writes: write 0x12345678 to addr 0 -> wr_ack=1, reg0 stays 0. Then back-to-back writes to addr 3 of 0x1 and 0x2 -> reg3=0x2, two consecutive wr_ack pulses.
4. Clear sequence: fill all regs with 0xA5A5A5A5, then pulse clr_req -> clr_busy high for exactly 32 cycles with reg i zero after the i-th busy cycle; wr_ready=0 throughout; clr_done high for one cycle; all regs 0.
5. Collision: in IDLE drive wr_en=1, addr=9, data=0x55 together with clr_req=1 -> wr_ack for addr 9 next cycle, then clear runs and reg9=0 at clr_done. A wr_en held during CLEAR yields no ack until the first IDLE cycle.
6. Reset mid-clear: assert rst at clear cycle 10 -> next cycle state IDLE, clr_busy=0, no clr_done, all regs 0.
